cdu_pulse_bank: RTL and testbench
=================================

Name: cdu_pulse_bank

Overview:
- Parametrised multi-channel successor to the single-axis CDU read-counter path.
- Holds NCHAN angle read counters, each driven by up/down step requests from that channel's quantizer/tracking loop.
- Queues the resulting incremental counts and transmits them to the AGC as rate-limited ±ΔΘ pulses.
- Supports a selectable 3200/6400 pps slot rate, per-channel enable, zeroing and overflow detection.

Parameters:
- NCHAN, 3, number of independent CDU channels.
- CNT_W, 16, read-counter width in bits; the counter wraps modulo 2^CNT_W.
- PEND_W, 5, width of the signed pending-pulse accumulator; valid range is ±(2^(PEND_W-1)-1).
- DIV, 16, CLOCKH cycles per pulse slot in normal mode (51.2 kHz / 16 = 3200 pps).
- FAST_DIV, 8, CLOCKH cycles per pulse slot in fast mode (6400 pps). FAST_DIV must be ≤ DIV and ≥ 2.

Ports:
- CLOCKH  input  1  51.2 kHz system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fast_mode  input  1  1 selects FAST_DIV slots, 0 selects DIV slots.
- chan_en  input  NCHAN  per-channel enable.
- step_up  input  NCHAN  one-cycle request: read counter +1.
- step_dn  input  NCHAN  one-cycle request: read counter -1.
- zero  input  NCHAN  synchronous clear of that channel's counter, pending accumulator and overflow flag.
- angle  output  NCHAN*CNT_W  read counters; channel i occupies bits [i*CNT_W +: CNT_W].
- agc_plus  output  NCHAN  one-cycle +ΔΘ pulse to the AGC.
- agc_minus  output  NCHAN  one-cycle -ΔΘ pulse to the AGC.
- overflow  output  NCHAN  sticky flag: the pending accumulator saturated.
- busy  output  1  OR over all channels of (pending ≠ 0).

Behaviour:
- Reset (rst_n=0, asynchronous): angle, pending, overflow, agc_plus, agc_minus, divider and busy all go to 0.
- Per-channel net step:
  - up&!dn → +1; dn&!up → -1; both or neither → 0.
  - Only counted when chan_en=1 and zero=0.
- Read counter:
  - angle ← angle + net on the same edge as the request.
  - Wraps: 0xFFFF+1 → 0x0000 and 0x0000-1 → 0xFFFF (CNT_W=16).
- Slot divider:
  - Free-running counter; limit L = FAST_DIV when fast_mode=1, else DIV.
  - tick is asserted in a cycle when div_cnt ≥ L-1; on that edge div_cnt ← 0, otherwise div_cnt+1.
  - A fast_mode change takes effect immediately. If div_cnt is already ≥ L-1, tick occurs next cycle.
- Transmit, on a tick edge, per channel with chan_en=1, zero=0 and pending≠0:
  - pending>0 → agc_plus ← 1 and pending -1.
  - pending<0 → agc_minus ← 1 and pending +1.
- agc_plus and agc_minus:
  - Registered; high exactly one cycle, in the cycle after the tick cycle; 0 otherwise.
  - Never both high on the same channel.
- Pending update per edge: pending ← pending + net − sent.
  - sent = +1 for a plus pulse, −1 for a minus pulse, 0 otherwise.
  - A step coinciding with a send is netted. Example: pending=+1, tick, step_dn → plus pulse issued, pending = -1.
- Saturation:
  - If the computed pending exceeds +(2^(PEND_W-1)-1) or falls below its negative, clamp it and set overflow=1.
  - The angle is still updated, so the AGC loses counts.
  - overflow clears only on zero or reset.
- zero:
  - Has priority over steps and tick for that channel.
  - Next state: angle=0, pending=0, overflow=0, and no pulse issued next cycle.
  - Other channels are unaffected.
- chan_en=0:
  - Steps are ignored and no pulses are issued.
  - pending and angle hold their values; overflow holds.
  - Re-enabling resumes draining at the next tick.
- busy: combinational OR of (pending≠0) across channels, from registered state.
- Maximum drain rate: one pulse per channel per slot. All channels transmit in parallel on the shared tick.

Test Plan:
- Reset, then 5 step_up on ch0 in consecutive cycles, fast_mode=0 → angle0=5 immediately; 5 agc_plus pulses, one per 16 cycles, each 1 cycle wide; busy drops after the 5th; agc_minus never high.
- ch1 angle=0x0000, 1 step_dn → angle1=0xFFFF and one agc_minus. Then 2 step_up → angle1=0x0001 and two agc_plus.
- ch2 receives 20 step_up back-to-back (PEND_W=5, max +15) → pending clamps at 15 and overflow2=1; angle2=20. A zero pulse → angle2=0, overflow2=0, no further pulses.
- step_up and step_dn asserted together on ch0 for 4 cycles → angle0 unchanged, no pulses, busy=0.
- fast_mode=1 with 8 pending on ch0 → pulses 8 cycles apart. Switching to fast_mode=1 mid-slot at div_cnt=12 → tick on the very next cycle.
- chan_en1=0 with pending=3 → no pulses for 100 cycles and step_up ignored. Re-enable → 3 pulses at the slot rate. An rst_n low asserted mid-pulse clears agc_plus within the same cycle.

Source files
------------

// File: rtl/cdu_pulse_bank_if.sv
// ----------------------------------------------------------------------------
// cdu_pulse_bank_if
// Signal bundle between a controller (quantizer/tracking loops plus mode and
// enable controls) and the CDU pulse bank.
//   master : drives fast_mode, chan_en, step_up, step_dn and zero;
//            observes angle, agc_plus, agc_minus, overflow and busy.
//   slave  : the pulse bank itself (the mirror image of master).
// angle packs channel i into bits [i*CNT_W +: CNT_W].
// ----------------------------------------------------------------------------
interface cdu_pulse_bank_if #(
    parameter int NCHAN = 3,
    parameter int CNT_W = 16
);
    logic                   fast_mode;
    logic [NCHAN-1:0]       chan_en;
    logic [NCHAN-1:0]       step_up;
    logic [NCHAN-1:0]       step_dn;
    logic [NCHAN-1:0]       zero;
    logic [NCHAN*CNT_W-1:0] angle;
    logic [NCHAN-1:0]       agc_plus;
    logic [NCHAN-1:0]       agc_minus;
    logic [NCHAN-1:0]       overflow;
    logic                   busy;

    modport master (
        output fast_mode, chan_en, step_up, step_dn, zero,
        input  angle, agc_plus, agc_minus, overflow, busy
    );

    modport slave (
        input  fast_mode, chan_en, step_up, step_dn, zero,
        output angle, agc_plus, agc_minus, overflow, busy
    );
endinterface

// File: rtl/cdu_pulse_bank.sv
// ----------------------------------------------------------------------------
// cdu_pulse_bank
// NCHAN independent CDU read counters. Each channel counts up/down step
// requests into a wrapping angle register and into a signed, saturating
// pending accumulator. The pending counts are drained towards the AGC as
// one-cycle +dTheta / -dTheta pulses, at most one per channel per slot. All
// channels share one slot divider (DIV or FAST_DIV cycles per slot).
// Ports:
//   CLOCKH : system clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of cdu_pulse_bank_if (controls in, counters,
//            AGC pulses, overflow flags and busy out)
// ----------------------------------------------------------------------------
module cdu_pulse_bank #(
    parameter int NCHAN    = 3,
    parameter int CNT_W    = 16,
    parameter int PEND_W   = 5,
    parameter int DIV      = 16,
    parameter int FAST_DIV = 8
) (
    input  logic               CLOCKH,
    input  logic               rst_n,
    cdu_pulse_bank_if.slave    bus
);
    // Divider only ever holds 0..DIV-1.
    localparam int DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
    // One extra bit so pending + net - sent cannot wrap before clamping.
    localparam int SUM_W    = PEND_W + 1;
    localparam int PEND_MAX = (1 << (PEND_W - 1)) - 1;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(PEND_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = -SUM_MAX;

    // ------------------------------------------------------------------
    // Shared slot divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] lim_m1;
    logic             tick;

    always_comb begin
        lim_m1    = bus.fast_mode ? DIV_W'(FAST_DIV - 1) : DIV_W'(DIV - 1);
        // ">=" rather than "==": switching to the shorter slot while the
        // count is already past its end must still produce a tick.
        tick      = (div_cnt_q >= lim_m1);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel counters
    // ------------------------------------------------------------------
    logic [NCHAN-1:0] pend_nz;

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        logic [CNT_W-1:0]        angle_q, angle_d;
        logic signed [PEND_W-1:0] pend_q, pend_d;
        logic                    ovf_q, ovf_d;
        logic                    plus_q, plus_d;
        logic                    minus_q, minus_d;
        logic                    active;
        logic signed [SUM_W-1:0] net;
        logic signed [SUM_W-1:0] sent;
        logic signed [SUM_W-1:0] sum;

        always_comb begin
            active  = bus.chan_en[gi] & ~bus.zero[gi];

            net = '0;
            if (active && bus.step_up[gi] && !bus.step_dn[gi]) begin
                net = SUM_W'(1);
            end else if (active && bus.step_dn[gi] && !bus.step_up[gi]) begin
                net = '1;
            end

            // Sign of the registered accumulator picks the pulse polarity.
            plus_d  = active & tick & ~pend_q[PEND_W-1] & (pend_q != '0);
            minus_d = active & tick & pend_q[PEND_W-1];

            sent = '0;
            if (plus_d) begin
                sent = SUM_W'(1);
            end else if (minus_d) begin
                sent = '1;
            end

            sum     = SUM_W'(pend_q) + net - sent;
            pend_d  = PEND_W'(sum);
            ovf_d   = ovf_q;
            if (sum > SUM_MAX) begin
                pend_d = PEND_W'(SUM_MAX);
                ovf_d  = 1'b1;
            end else if (sum < SUM_MIN) begin
                pend_d = PEND_W'(SUM_MIN);
                ovf_d  = 1'b1;
            end

            // The angle always follows the steps, even when pending clamps.
            angle_d = angle_q + CNT_W'(net);

            // zero wins over everything else on this channel; active is
            // already low, so no pulse is produced either.
            if (bus.zero[gi]) begin
                angle_d = '0;
                pend_d  = '0;
                ovf_d   = 1'b0;
            end
        end

        always_ff @(posedge CLOCKH or negedge rst_n) begin
            if (!rst_n) begin
                angle_q <= '0;
                pend_q  <= '0;
                ovf_q   <= 1'b0;
                plus_q  <= 1'b0;
                minus_q <= 1'b0;
            end else begin
                angle_q <= angle_d;
                pend_q  <= pend_d;
                ovf_q   <= ovf_d;
                plus_q  <= plus_d;
                minus_q <= minus_d;
            end
        end

        assign bus.angle[gi*CNT_W +: CNT_W] = angle_q;
        assign bus.agc_plus[gi]             = plus_q;
        assign bus.agc_minus[gi]            = minus_q;
        assign bus.overflow[gi]             = ovf_q;
        assign pend_nz[gi]                  = (pend_q != '0);
    end

    assign bus.busy = |pend_nz;

endmodule

// File: tb/tb_cdu_pulse_bank.sv
// ----------------------------------------------------------------------------
// tb_cdu_pulse_bank
// Directed scenarios followed by a randomized phase. A behavioural model,
// stepped alongside the stimulus, pushes every expected AGC pulse (cycle,
// channel, polarity) into a queue; an independent monitor pops it when the
// DUT shows a pulse, and compares angle, overflow and busy every cycle.
// ----------------------------------------------------------------------------
module tb_cdu_pulse_bank;
    localparam int NCHAN    = 3;
    localparam int CNT_W    = 16;
    localparam int PEND_W   = 5;
    localparam int DIV      = 16;
    localparam int FAST_DIV = 8;
    localparam int PMAX     = (1 << (PEND_W - 1)) - 1;
    localparam int AMASK    = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdu_pulse_bank_if #(.NCHAN(NCHAN), .CNT_W(CNT_W)) bus ();

    cdu_pulse_bank #(
        .NCHAN(NCHAN), .CNT_W(CNT_W), .PEND_W(PEND_W),
        .DIV(DIV), .FAST_DIV(FAST_DIV)
    ) dut (
        .CLOCKH (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // ---------------- scoreboard / model state ----------------
    typedef struct {
        int cyc;
        int ch;
        bit plus;
    } ev_t;
    ev_t exp_q[$];

    int m_angle [NCHAN];
    int m_pend  [NCHAN];
    bit m_ovf   [NCHAN];
    int m_div;
    int cyc;
    int n_checks;
    int n_pass;
    bit drv_rst_n;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Next state of the model for the coming rising edge, from the rules:
    // steps net to +1/-1/0, one pulse per slot drains pending, clamp at
    // +-PMAX with a sticky flag, zero clears, disabled channels freeze.
    function automatic void model_step(input bit fast, input logic [NCHAN-1:0] en,
                                       input logic [NCHAN-1:0] up, input logic [NCHAN-1:0] dn,
                                       input logic [NCHAN-1:0] zr);
        int  lim;
        bit  tick;
        int  net;
        int  sent;
        int  p;
        if (!drv_rst_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                m_angle[c] = 0; m_pend[c] = 0; m_ovf[c] = 1'b0;
            end
            m_div = 0;
            return;
        end
        lim   = fast ? FAST_DIV : DIV;
        tick  = (m_div >= lim - 1);
        m_div = tick ? 0 : m_div + 1;
        for (int c = 0; c < NCHAN; c++) begin
            if (zr[c]) begin
                m_angle[c] = 0; m_pend[c] = 0; m_ovf[c] = 1'b0;
            end else if (en[c]) begin
                net  = int'(up[c]) - int'(dn[c]);
                sent = 0;
                if (tick && m_pend[c] > 0) sent = 1;
                else if (tick && m_pend[c] < 0) sent = -1;
                if (sent != 0) exp_q.push_back('{cyc + 1, c, sent > 0});
                m_angle[c] = (m_angle[c] + net) & AMASK;
                p = m_pend[c] + net - sent;
                if (p > PMAX) begin p = PMAX; m_ovf[c] = 1'b1; end
                else if (p < -PMAX) begin p = -PMAX; m_ovf[c] = 1'b1; end
                m_pend[c] = p;
            end
        end
    endfunction

    // One clock of stimulus, applied on the falling edge.
    task automatic step(input bit fast, input logic [NCHAN-1:0] en,
                        input logic [NCHAN-1:0] up, input logic [NCHAN-1:0] dn,
                        input logic [NCHAN-1:0] zr);
        @(negedge clk);
        rst_n         = drv_rst_n;
        bus.fast_mode = fast;
        bus.chan_en   = en;
        bus.step_up   = up;
        bus.step_dn   = dn;
        bus.zero      = zr;
        model_step(fast, en, up, dn, zr);
    endtask

    task automatic idle(input int n, input bit fast, input logic [NCHAN-1:0] en);
        for (int i = 0; i < n; i++) step(fast, en, '0, '0, '0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        bit found;
        bit busy_exp;
        #1;
        cyc++;
        // Expected pulses whose cycle has passed were never shown.
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            $display("FAIL missing_pulse: got none, required %s on ch%0d at cycle %0d",
                     exp_q[0].plus ? "plus" : "minus", exp_q[0].ch, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        for (int c = 0; c < NCHAN; c++) begin
            if (bus.agc_plus[c] || bus.agc_minus[c]) begin
                n_checks++;
                found = 1'b0;
                if (bus.agc_plus[c] && bus.agc_minus[c]) begin
                    $display("FAIL pulse_both ch%0d: got plus=1 minus=1, required at most one (cycle %0d)", c, cyc);
                end else begin
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (!found && exp_q[k].cyc == cyc && exp_q[k].ch == c &&
                            exp_q[k].plus == bus.agc_plus[c]) begin
                            found = 1'b1;
                            exp_q.delete(k);
                            break;
                        end
                    end
                    if (found) n_pass++;
                    else $display("FAIL unexpected_pulse ch%0d: got %s, required no pulse (cycle %0d)",
                                  c, bus.agc_plus[c] ? "plus" : "minus", cyc);
                end
            end
        end
        busy_exp = 1'b0;
        for (int c = 0; c < NCHAN; c++) begin
            chk($sformatf("angle%0d", c), int'(bus.angle[c*CNT_W +: CNT_W]), m_angle[c]);
            chk($sformatf("overflow%0d", c), int'(bus.overflow[c]), int'(m_ovf[c]));
            if (m_pend[c] != 0) busy_exp = 1'b1;
        end
        chk("busy", int'(bus.busy), int'(busy_exp));
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NCHAN-1:0] en, up, dn, zr;
        bit               fast;
        bit               hit;
        int               guard;

        n_checks = 0; n_pass = 0; cyc = 0; m_div = 0;
        for (int c = 0; c < NCHAN; c++) begin
            m_angle[c] = 0; m_pend[c] = 0; m_ovf[c] = 1'b0;
        end
        bus.fast_mode = 1'b0; bus.chan_en = '0; bus.step_up = '0;
        bus.step_dn = '0; bus.zero = '0;

        // Reset held, then released.
        drv_rst_n = 1'b0;
        idle(3, 1'b0, '1);
        chk("reset_plus", int'(bus.agc_plus), 0);
        chk("reset_minus", int'(bus.agc_minus), 0);
        drv_rst_n = 1'b1;

        // Five up-steps on ch0, normal rate.
        for (int i = 0; i < 5; i++) step(1'b0, '1, 3'b001, '0, '0);
        idle(100, 1'b0, '1);

        // ch1 wraps down to 0xFFFF, then back up to 0x0001.
        step(1'b0, '1, '0, 3'b010, '0);
        idle(30, 1'b0, '1);
        step(1'b0, '1, 3'b010, '0, '0);
        step(1'b0, '1, 3'b010, '0, '0);
        idle(50, 1'b0, '1);

        // ch2 saturates, then is zeroed.
        for (int i = 0; i < 20; i++) step(1'b0, '1, 3'b100, '0, '0);
        idle(20, 1'b0, '1);
        step(1'b0, '1, '0, '0, 3'b100);
        idle(40, 1'b0, '1);

        // Simultaneous up and down cancel.
        for (int i = 0; i < 4; i++) step(1'b0, '1, 3'b001, 3'b001, '0);
        idle(20, 1'b0, '1);

        // Fast slots with 8 pending.
        for (int i = 0; i < 8; i++) step(1'b1, '1, 3'b001, '0, '0);
        idle(80, 1'b1, '1);

        // Switch to fast mode while the divider sits at 12.
        for (int i = 0; i < 3; i++) step(1'b0, '1, 3'b001, '0, '0);
        guard = 0;
        while (m_div != 12 && guard < 40) begin
            step(1'b0, '1, '0, '0, '0);
            guard++;
        end
        chk("div_reached_12", m_div, 12);
        idle(40, 1'b1, '1);

        // ch1 disabled with pending counts: frozen, steps ignored.
        for (int i = 0; i < 3; i++) step(1'b0, '1, 3'b010, '0, '0);
        for (int i = 0; i < 100; i++) step(1'b0, 3'b101, (i % 7 == 0) ? 3'b010 : 3'b000, '0, '0);
        idle(80, 1'b0, '1);

        // Asynchronous reset while a plus pulse is showing.
        for (int i = 0; i < 4; i++) step(1'b0, '1, 3'b001, '0, '0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step(1'b0, '1, '0, '0, '0);
            @(posedge clk);
            #3;
            if (bus.agc_plus != '0) begin
                hit       = 1'b1;
                drv_rst_n = 1'b0;
                rst_n     = 1'b0;
                #1;
                chk("async_rst_plus", int'(bus.agc_plus), 0);
            end
        end
        chk("rst_pulse_seen", int'(hit), 1);
        idle(2, 1'b0, '1);
        drv_rst_n = 1'b1;
        idle(5, 1'b0, '1);

        // Randomized traffic.
        fast = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) == 0) fast = ~fast;
            for (int c = 0; c < NCHAN; c++) begin
                en[c] = ($urandom_range(0, 7) != 0);
                up[c] = ($urandom_range(0, 3) == 0);
                dn[c] = ($urandom_range(0, 3) == 0);
                zr[c] = ($urandom_range(0, 63) == 0);
            end
            step(fast, en, up, dn, zr);
        end

        // Drain everything that is left.
        idle(300, 1'b1, '1);
        @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL missing_pulse: got none, required %s on ch%0d at cycle %0d",
                     exp_q[0].plus ? "plus" : "minus", exp_q[0].ch, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
